// File: rtl/squeezer_sequencer.sv
// Control sequencer for a bit-serial squeezer modular multiplier: one SHIFT/CHECK pair per multiplier bit,
// with up to MAX_SQ squeeze corrections per bit. Define SQUEEZER_SEQ_ERR_EN to stop with err on squeeze overflow.
module squeezer_sequencer #(
    parameter int N      = 1 << 16,
    parameter int CW     = $clog2(N),
    parameter int MAX_SQ = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    rule,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          ld_en,
    output logic          shift_en,
    output logic          add_en,
    output logic          sq_en,
    output logic          final_en,
    output logic [2:0]    sq_rule,
    output logic [CW-1:0] bit_idx
);

    localparam int SW = (MAX_SQ < 1) ? 1 : $clog2(MAX_SQ + 1);
    localparam logic [SW-1:0] MAX_SQ_C = SW'(MAX_SQ);
    localparam logic [CW-1:0] IDX_TOP  = CW'(N - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CHECK   = 3'd3,
        ST_SQUEEZE = 3'd4,
        ST_FINAL   = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERR     = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   bit_idx_q, bit_idx_d;
    logic [SW-1:0]   sq_cnt_q, sq_cnt_d;
    logic [2:0]      sq_rule_q, sq_rule_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ld_en_q, ld_en_d;
    logic            shift_en_q, shift_en_d;
    logic            add_en_q, add_en_d;
    logic            sq_en_q, sq_en_d;
    logic            final_en_q, final_en_d;
`ifdef SQUEEZER_SEQ_ERR_EN
    logic            err_q, err_d;
`endif

    logic            needs_corr;
    logic            next_iter;

    // Rules 1, 6 and 7 mean the partial result is already in range.
    assign needs_corr = !((rule == 3'd1) || (rule == 3'd6) || (rule == 3'd7));

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        sq_cnt_d   = sq_cnt_q;
        sq_rule_d  = 3'd0;
        next_iter  = 1'b0;
`ifdef SQUEEZER_SEQ_ERR_EN
        err_d      = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                sq_cnt_d = '0;
                state_d  = ST_CHECK;
            end
            ST_CHECK: begin
                if (!needs_corr) begin
                    next_iter = 1'b1;
                end else if (sq_cnt_q < MAX_SQ_C) begin
                    sq_rule_d = rule;
                    state_d   = ST_SQUEEZE;
                end else begin
`ifdef SQUEEZER_SEQ_ERR_EN
                    err_d   = 1'b1;
                    state_d = ST_ERR;
`else
                    next_iter = 1'b1;
`endif
                end
            end
            ST_SQUEEZE: begin
                sq_cnt_d = sq_cnt_q + SW'(1);
                state_d  = ST_CHECK;
            end
            ST_FINAL: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (next_iter) begin
            if (bit_idx_q == '0) begin
                state_d = ST_FINAL;
            end else begin
                bit_idx_d = bit_idx_q - CW'(1);
                state_d   = ST_SHIFT;
            end
        end

        // Strobes are decoded from the next state so they are registered and line up with their state.
        busy_d     = (state_d != ST_IDLE);
        ld_en_d    = (state_d == ST_LOAD);
        shift_en_d = (state_d == ST_SHIFT);
        add_en_d   = (state_d == ST_SHIFT);
        sq_en_d    = (state_d == ST_SQUEEZE);
        final_en_d = (state_d == ST_FINAL);
        done_d     = (state_d == ST_DONE) || (state_d == ST_ERR);

        if (state_d == ST_LOAD) begin
            bit_idx_d = IDX_TOP;
`ifdef SQUEEZER_SEQ_ERR_EN
            err_d     = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_idx_q  <= '0;
            sq_cnt_q   <= '0;
            sq_rule_q  <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ld_en_q    <= 1'b0;
            shift_en_q <= 1'b0;
            add_en_q   <= 1'b0;
            sq_en_q    <= 1'b0;
            final_en_q <= 1'b0;
`ifdef SQUEEZER_SEQ_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            sq_cnt_q   <= sq_cnt_d;
            sq_rule_q  <= sq_rule_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ld_en_q    <= ld_en_d;
            shift_en_q <= shift_en_d;
            add_en_q   <= add_en_d;
            sq_en_q    <= sq_en_d;
            final_en_q <= final_en_d;
`ifdef SQUEEZER_SEQ_ERR_EN
            err_q      <= err_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ld_en    = ld_en_q;
    assign shift_en = shift_en_q;
    assign add_en   = add_en_q;
    assign sq_en    = sq_en_q;
    assign final_en = final_en_q;
    assign sq_rule  = sq_rule_q;
    assign bit_idx  = bit_idx_q;
`ifdef SQUEEZER_SEQ_ERR_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_squeezer_sequencer.sv
// Self-checking bench for squeezer_sequencer with N=4, MAX_SQ=3: per-cycle vector tables plus
// hand-written overflow, busy-start and mid-squeeze reset sequences.
module tb_squeezer_sequencer;

    localparam int N      = 4;
    localparam int CW     = 2;
    localparam int MAX_SQ = 3;

`ifdef SQUEEZER_SEQ_ERR_EN
    localparam int  OVF_SQ      = MAX_SQ;
    localparam int  OVF_DONE    = 10;
    localparam logic OVF_ERR    = 1'b1;
`else
    localparam int  OVF_SQ      = MAX_SQ * N;
    localparam int  OVF_DONE    = 2 * N + 3 + 6 * N;
    localparam logic OVF_ERR    = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    rule = 3'd1;
    logic          busy, done, err, ld_en, shift_en, add_en, sq_en, final_en;
    logic [2:0]    sq_rule;
    logic [CW-1:0] bit_idx;

    int errors = 0;
    int checks = 0;

    squeezer_sequencer #(.N(N), .CW(CW), .MAX_SQ(MAX_SQ)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rule     (rule),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .ld_en    (ld_en),
        .shift_en (shift_en),
        .add_en   (add_en),
        .sq_en    (sq_en),
        .final_en (final_en),
        .sq_rule  (sq_rule),
        .bit_idx  (bit_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          start;
        logic [2:0]    rule;
        logic [7:0]    flags;   // {busy, done, err, ld_en, shift_en, add_en, sq_en, final_en}
        logic [2:0]    sq_rule;
        logic [CW-1:0] bit_idx;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic st, input logic [2:0] r, input logic [7:0] f,
                                    input logic [2:0] sqr, input logic [CW-1:0] bi);
        vec_t v;
        v.start = st; v.rule = r; v.flags = f; v.sq_rule = sqr; v.bit_idx = bi;
        vecs.push_back(v);
    endfunction

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            check($sformatf("vec%0d.flags", i),
                  {busy, done, err, ld_en, shift_en, add_en, sq_en, final_en}, vecs[i].flags);
            check($sformatf("vec%0d.sq_rule", i), sq_rule, vecs[i].sq_rule);
            check($sformatf("vec%0d.bit_idx", i), bit_idx, vecs[i].bit_idx);
            check($sformatf("vec%0d.exclusive", i),
                  ($countones({ld_en, shift_en, sq_en, final_en}) <= 1), 1);
            start = vecs[i].start;
            rule  = vecs[i].rule;
        end
        start = 1'b0;
    endtask

    // Pulses start at the next negedge (cycle 0) and watches until done, counting events on the way.
    task automatic run_op(input logic [2:0] r, input int busy_start_at,
                          output int done_cyc, output int sq_seen, output int ld_seen,
                          output logic err_at_done, output int bad_rule, output int multi);
        done_cyc = -1; sq_seen = 0; ld_seen = 0; err_at_done = 1'bx; bad_rule = 0; multi = 0;
        @(negedge clk);
        start = 1'b1;
        rule  = r;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            start = (c == busy_start_at);
            if (sq_en) begin
                sq_seen++;
                if (sq_rule != r) bad_rule++;
            end else if (sq_rule != 3'd0) begin
                bad_rule++;
            end
            if (ld_en) ld_seen++;
            if ($countones({ld_en, shift_en, sq_en, final_en}) > 1) multi++;
            if (done) begin
                done_cyc    = c;
                err_at_done = err;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int   done_cyc, sq_seen, ld_seen, bad_rule, multi;
        logic err_at_done;

        // Rule held at 1: one LOAD, four SHIFT/CHECK pairs, FINAL at 10, DONE at 11.
        add_vec(1, 1, 8'b0000_0000, 0, 0);
        add_vec(0, 1, 8'b1001_0000, 0, 3);
        add_vec(0, 1, 8'b1000_1100, 0, 3);
        add_vec(0, 1, 8'b1000_0000, 0, 3);
        add_vec(0, 1, 8'b1000_1100, 0, 2);
        add_vec(0, 1, 8'b1000_0000, 0, 2);
        add_vec(0, 1, 8'b1000_1100, 0, 1);
        add_vec(0, 1, 8'b1000_0000, 0, 1);
        add_vec(0, 1, 8'b1000_1100, 0, 0);
        add_vec(0, 1, 8'b1000_0000, 0, 0);
        add_vec(0, 1, 8'b1000_0001, 0, 0);
        add_vec(0, 1, 8'b1100_0000, 0, 0);
        add_vec(0, 1, 8'b0000_0000, 0, 0);
        // Rule 3 on the first CHECK only: one squeeze, DONE at 13.
        add_vec(1, 1, 8'b0000_0000, 0, 0);
        add_vec(0, 1, 8'b1001_0000, 0, 3);
        add_vec(0, 1, 8'b1000_1100, 0, 3);
        add_vec(0, 3, 8'b1000_0000, 0, 3);
        add_vec(0, 1, 8'b1000_0010, 3, 3);
        add_vec(0, 1, 8'b1000_0000, 0, 3);
        add_vec(0, 1, 8'b1000_1100, 0, 2);
        add_vec(0, 1, 8'b1000_0000, 0, 2);
        add_vec(0, 1, 8'b1000_1100, 0, 1);
        add_vec(0, 1, 8'b1000_0000, 0, 1);
        add_vec(0, 1, 8'b1000_1100, 0, 0);
        add_vec(0, 1, 8'b1000_0000, 0, 0);
        add_vec(0, 1, 8'b1000_0001, 0, 0);
        add_vec(0, 1, 8'b1100_0000, 0, 0);
        add_vec(0, 1, 8'b0000_0000, 0, 0);

        @(negedge clk);
        check("reset.flags", {busy, done, err, ld_en, shift_en, add_en, sq_en, final_en}, 8'h00);
        check("reset.sq_rule", sq_rule, 0);
        check("reset.bit_idx", bit_idx, 0);
        rst_n = 1'b1;

        run_vecs();

        // Rule held at 5 with a start pulse while busy at cycle 5.
        run_op(3'd5, 5, done_cyc, sq_seen, ld_seen, err_at_done, bad_rule, multi);
        check("ovf.done_cycle", done_cyc, OVF_DONE);
        check("ovf.sq_pulses", sq_seen, OVF_SQ);
        check("ovf.err_at_done", err_at_done, OVF_ERR);
        check("ovf.ld_pulses", ld_seen, 1);
        check("ovf.sq_rule", bad_rule, 0);
        check("ovf.exclusive", multi, 0);
        rule = 3'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("ovf.idle%0d.busy", i), busy, 0);
            check($sformatf("ovf.idle%0d.err", i), err, OVF_ERR);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart.ld_en", ld_en, 1);
        check("restart.err", err, 0);
        for (int c = 2; c <= 40 && !done; c++) @(negedge clk);
        check("restart.done", done, 1);
        @(negedge clk);

        // Reset asserted during a SQUEEZE cycle.
        start = 1'b1; rule = 3'd1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rule = 3'd3;
        @(negedge clk);
        check("rst_sq.pre_sq_en", sq_en, 1);
        rst_n = 1'b0;
        #1;
        check("rst_sq.flags", {busy, done, err, ld_en, shift_en, add_en, sq_en, final_en}, 8'h00);
        check("rst_sq.sq_rule", sq_rule, 0);
        check("rst_sq.bit_idx", bit_idx, 0);
        @(negedge clk);
        rst_n = 1'b1; rule = 3'd1;
        @(negedge clk);
        @(negedge clk);
        check("rst_sq.idle_busy", busy, 0);

        run_op(3'd1, 0, done_cyc, sq_seen, ld_seen, err_at_done, bad_rule, multi);
        check("after_rst.done_cycle", done_cyc, 2 * N + 3);
        check("after_rst.sq_pulses", sq_seen, 0);
        check("after_rst.err", err_at_done, 0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/squeezer_sequencer.md
SQUEEZER_SEQUENCER -- requirements
Module: squeezer_sequencer

Interface
REQ-001 SHALL have parameter N, default 1<<16, the operand width in bits, which is also the iteration count.
REQ-002 SHALL have parameter CW, default $clog2(N), the width of the bit-index counter.
REQ-003 SHALL have parameter MAX_SQ, default 3, the maximum number of squeeze passes per iteration.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit: request to begin one modular multiplication.
REQ-007 SHALL have port rule, input, 3 bits: combinational rule code from the squeezer rule logic.
REQ-008 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-010 SHALL have port err, output, 1 bit: squeeze-overflow flag.
REQ-011 SHALL have ports ld_en, shift_en, add_en, sq_en and final_en, each output, 1 bit: single-cycle datapath strobes.
REQ-012 SHALL have port sq_rule, output, 3 bits: registered rule applied during a SQUEEZE cycle.
REQ-013 SHALL have port bit_idx, output, CW bits: multiplier bit selector for the datapath.

Function
REQ-014 SHALL implement the states IDLE, LOAD, SHIFT, CHECK, SQUEEZE, FINAL, DONE and ERR.
REQ-015 SHALL go from IDLE to LOAD when start=1; start SHALL be ignored in every state other than IDLE.
REQ-016 SHALL in LOAD assert ld_en, set bit_idx to N-1, and go to SHIFT.
REQ-017 SHALL in SHIFT assert shift_en and add_en, clear the squeeze counter sq_cnt, and go to CHECK.
REQ-018 SHALL in CHECK, when rule is 1, 6 or 7 (no correction):
- if bit_idx=0, go to FINAL;
- otherwise, decrement bit_idx and go to SHIFT.
REQ-019 SHALL in CHECK, when rule is 0 or 2..5 and sq_cnt<MAX_SQ, load sq_rule with rule and go to SQUEEZE.
REQ-020 SHALL in SQUEEZE assert sq_en, hold sq_rule, increment sq_cnt, and go to CHECK.
REQ-021 SHALL in CHECK, when rule needs correction and sq_cnt=MAX_SQ, follow the overflow behaviour defined in REQ-030/REQ-031.
REQ-022 SHALL in FINAL assert final_en and go to DONE; in DONE assert done and go to IDLE.
REQ-023 SHALL in ERR assert done and go to IDLE.
REQ-024 SHALL, with no squeezes, assert done exactly 2N+3 cycles after the cycle in which start is sampled; each squeeze pass SHALL add 2 cycles.
REQ-025 SHALL never assert more than one of ld_en, shift_en, sq_en and final_en in the same cycle.
REQ-026 SHALL drive sq_rule to 0 in every cycle that is not a SQUEEZE cycle.

Reset
REQ-027 SHALL, on rst_n low, at any time including mid-operation, immediately enter IDLE.
REQ-028 SHALL hold every output at 0 and clear bit_idx, sq_cnt and sq_rule while rst_n is low.
REQ-029 SHALL resume normal operation on the first rising clk edge after rst_n is released, with no start pending.

Configuration
REQ-030 SHALL, with macro SQUEEZER_SEQ_ERR_EN defined, handle overflow in CHECK as follows:
- go to ERR;
- set err, which stays high until the next start is accepted, and is cleared in LOAD.
REQ-031 SHALL, without SQUEEZER_SEQ_ERR_EN, treat overflow in CHECK as rule 1, continuing to the next iteration, and tie err to 0.

Verification
REQ-032 SHALL cover: N=4, rule held at 1, start pulsed -> ld_en at cycle 1, four shift_en pulses, final_en at cycle 10, done at cycle 11, bit_idx counting 3,2,1,0.
REQ-033 SHALL cover: N=4, rule=3 for the first CHECK only -> one sq_en with sq_rule=3, done at cycle 13.
REQ-034 SHALL cover: rule held at 5 with the macro defined, MAX_SQ=3 -> three sq_en pulses, then err=1 and done in the same ERR cycle, err persists until the next start.
REQ-035 SHALL cover: the same stimulus without the macro -> three sq_en pulses per iteration, err=0, done at 2N+3+6N cycles.
REQ-036 SHALL cover: start pulsed while busy -> no effect on state; rst_n low during SQUEEZE -> all outputs 0 immediately and the state is IDLE.
